midi_tx_queue: RTL and testbench
================================

Name: midi_tx_queue

Overview:
- Byte queue and handshake adapter directly upstream of the MIDI UART serializer.
- Accepts MIDI bytes from the bus-side decoder over a valid/ready interface and buffers them in a FIFO.
- Presents one byte at a time on the serializer's uart_valid/uart_data inputs. The byte is held stable from offer until the serializer pulses uart_done.
- Optionally compresses MIDI running status before queueing.

Parameters:
DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 entries (16). Legal range 2..8.

Ports:
midi_system_clock  in  1  block clock; same clock as the serializer.
midi_rst_n  in  1  asynchronous active-low reset.
flush  in  1  one-cycle request to discard all queued (not yet offered-and-started) bytes.
in_valid  in  1  upstream byte valid.
in_ready  out  1  block can accept a byte this cycle.
in_data  in  8  upstream MIDI byte.
uart_valid  out  1  byte offered to serializer.
uart_data  out  8  offered/in-flight byte; stable while the serializer transmits.
uart_idle  in  1  serializer idle status.
uart_done  in  1  serializer one-cycle completion pulse (stop bit end).
level  out  DEPTH_LOG2+1  FIFO occupancy, excluding the hold register.
busy  out  1  high when FIFO non-empty or the FSM is not in S_EMPTY.

Behaviour:
- Reset (async assert, sync release): FIFO empty, level=0, FSM=S_EMPTY, hold=8'h00, uart_valid=0, uart_data=8'h00, in_ready=0 during reset, busy=0.
- Write side:
  - in_ready = (level < 2**DEPTH_LOG2) & ~flush.
  - Accept when in_valid & in_ready at a clock edge.
  - Push and pop in the same cycle leave level unchanged.
  - Full: in_ready=0; in_data is not written.
- Output FSM, hold register feeding uart_data:
  - S_EMPTY: uart_valid=0. If level>0, pop head into hold and go to S_OFFER.
    - A byte accepted at edge k appears on uart_data, with uart_valid=1, after edge k+1 (2-cycle latency when the block is idle).
  - S_OFFER: uart_valid=1. When uart_idle==0 is sampled (serializer has started), go to S_SEND. uart_valid stays high until that edge.
  - S_SEND: uart_valid=0, hold unchanged. On uart_done go to S_EMPTY.
    - No pop in the done cycle; the next byte is loaded the following cycle. This guarantees the serializer is back in idle before a new offer.
- uart_data = hold in every state.
- Flush:
  - FIFO pointers and level clear at the edge where flush=1; no write occurs that cycle.
  - In S_OFFER with uart_idle=1: return to S_EMPTY and drop uart_valid.
  - In S_OFFER with uart_idle=0: go to S_SEND. A started frame has priority.
  - In S_SEND: the frame completes normally. No frame is ever truncated.
- Pointer arithmetic: DEPTH_LOG2-bit read/write pointers wrap modulo depth. level is DEPTH_LOG2+1 bits, so it distinguishes full from empty.
- uart_done outside S_SEND is ignored.
- Asserting reset mid-frame forces uart_valid=0 immediately. The serializer shares the reset domain and is assumed reset too.

Optional Feature:
- Macro: MIDI_RUNNING_STATUS_EN.
- Defined:
  - A last_status register is cleared to 8'h00 on reset and on flush.
  - At accept, a byte in 8'h80..8'hEF equal to last_status is consumed: in_ready handshake completes, but nothing is pushed.
  - Otherwise a byte in 8'h80..8'hEF is pushed and updates last_status.
  - Bytes 8'hF0..8'hF7 are pushed and clear last_status.
  - Bytes 8'hF8..8'hFF (real-time) and data bytes are pushed without changing last_status.
- Undefined: every accepted byte is pushed unchanged and no last_status register exists.

Test Plan:
- Push 8'h90 into idle block -> uart_valid=1, uart_data=8'h90 two cycles after accept. Serializer model starts and pulses uart_done -> uart_valid=0, level=0, busy=0.
- Push 16 bytes 8'h00..8'h0F with serializer stalled in S_SEND -> after 16 accepts level=16, in_ready=0, and a 17th in_valid is not accepted. Drain -> bytes emerge in order 8'h00..8'h0F, each held stable until its uart_done.
- Push and pop in the same cycle at level=5 -> level stays 5. Run a pointer wrap-around over 40 bytes -> output order preserved.
- Flush in S_OFFER with uart_idle=1 and level=3 -> uart_valid=0 next cycle, level=0. Flush during S_SEND of 8'hB0 -> 8'hB0 completes, and uart_valid stays low after uart_done.
- MIDI_RUNNING_STATUS_EN defined: input 90 3C 40 90 3E 40 F8 90 40 40 -> output 90 3C 40 3E 40 F8 40 40. Input F2 90 -> 90 is sent after F2.
- Assert midi_rst_n low in S_SEND with level=4 -> uart_valid=0 and level=0 asynchronously. After release, in_ready=1 on the first clock.

Source files
------------

// File: rtl/midi_tx_queue.sv
// rtl/midi_tx_queue.sv - MIDI byte FIFO and hold-register handshake adapter feeding the UART serializer
//
// Optional feature macro: MIDI_RUNNING_STATUS_EN (running-status compression at the write side).
//
// Ports:
//   midi_system_clock  block clock, shared with the serializer
//   midi_rst_n         asynchronous active-low reset
//   flush              one-cycle discard of all queued, not-yet-started bytes
//   in_valid/in_ready  upstream byte handshake, in_data carries the byte
//   uart_valid         byte offered to the serializer
//   uart_data          offered / in-flight byte, always driven from the hold register
//   uart_idle          serializer idle status (low = frame started)
//   uart_done          serializer completion pulse
//   level              FIFO occupancy, excluding the hold register
//   busy               FIFO non-empty or output FSM not in S_EMPTY
module midi_tx_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  midi_system_clock,
    input  logic                  midi_rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    output logic                  uart_valid,
    output logic [7:0]            uart_data,
    input  logic                  uart_idle,
    input  logic                  uart_done,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_OFFER = 2'd1,
        S_SEND  = 2'd2
    } state_e;

    state_e                state_q;
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [7:0]            hold_q;
    logic                  uart_valid_q;
    logic                  accept;
    logic                  push;
    logic                  pop;

    // Gated by reset so the upstream never sees ready while the block is held in reset.
    assign in_ready = midi_rst_n & (level_q < LEVEL_FULL) & ~flush;
    assign accept   = in_valid & in_ready;

    // Load the hold register only from S_EMPTY; a flush in that cycle wins over the pop.
    assign pop = (state_q == S_EMPTY) && (level_q != '0) && !flush;

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] last_status_q, last_status_d;
    logic       is_chan_status;
    logic       is_sys_common;
    logic       rs_drop;

    always_comb begin
        is_chan_status = (in_data >= 8'h80) && (in_data <= 8'hEF);
        is_sys_common  = (in_data >= 8'hF0) && (in_data <= 8'hF7);
        // A repeated channel status is redundant: complete the handshake, queue nothing.
        rs_drop        = is_chan_status && (in_data == last_status_q);
        last_status_d  = last_status_q;
        if (flush) begin
            last_status_d = 8'h00;
        end else if (accept) begin
            if (is_chan_status) begin
                last_status_d = in_data;
            end else if (is_sys_common) begin
                last_status_d = 8'h00;
            end
        end
    end

    assign push = accept & ~rs_drop;

    always_ff @(posedge midi_system_clock or negedge midi_rst_n) begin
        if (!midi_rst_n) begin
            last_status_q <= 8'h00;
        end else begin
            last_status_q <= last_status_d;
        end
    end
`else
    assign push = accept;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                level_d = level_q + LEVEL_ONE;
            end else if (pop && !push) begin
                level_d = level_q - LEVEL_ONE;
            end
        end
    end

    always_ff @(posedge midi_system_clock or negedge midi_rst_n) begin
        if (!midi_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: level guards every read.
    always_ff @(posedge midi_system_clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge midi_system_clock or negedge midi_rst_n) begin
        if (!midi_rst_n) begin
            state_q      <= S_EMPTY;
            hold_q       <= 8'h00;
            uart_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (pop) begin
                        hold_q       <= mem_q[rd_ptr_q];
                        state_q      <= S_OFFER;
                        uart_valid_q <= 1'b1;
                    end
                end
                S_OFFER: begin
                    // A frame that has already started takes priority over flush.
                    if (!uart_idle) begin
                        state_q      <= S_SEND;
                        uart_valid_q <= 1'b0;
                    end else if (flush) begin
                        state_q      <= S_EMPTY;
                        uart_valid_q <= 1'b0;
                    end
                end
                S_SEND: begin
                    // No pop here: the next offer waits one cycle so the serializer is idle again.
                    if (uart_done) begin
                        state_q <= S_EMPTY;
                    end
                end
                default: begin
                    state_q      <= S_EMPTY;
                    uart_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign uart_valid = uart_valid_q;
    assign uart_data  = hold_q;
    assign level      = level_q;
    assign busy       = (level_q != '0) || (state_q != S_EMPTY);

endmodule

// File: tb/tb_midi_tx_queue.sv
// tb/tb_midi_tx_queue.sv - self-checking bench for midi_tx_queue with a behavioural serializer and byte-order model
module tb_midi_tx_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       uart_valid;
    logic [7:0] uart_data;
    logic       uart_idle;
    logic       uart_done;
    logic [4:0] level;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] out_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_last = 8'h00;
    logic [7:0] cap;
    bit         ser_en = 1'b0;
    bit         ser_stall = 1'b0;
    int         ser_len = 2;
    int         ser_bad = 0;
    int         d;

    midi_tx_queue #(.DEPTH_LOG2(4)) dut (
        .midi_system_clock(clk),
        .midi_rst_n(rst_n),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .uart_valid(uart_valid),
        .uart_data(uart_data),
        .uart_idle(uart_idle),
        .uart_done(uart_done),
        .level(level),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Serializer: starts on a valid offer, transmits ser_len cycles (or while stalled), pulses done.
    // While transmitting it requires uart_data stable and uart_valid low.
    initial begin
        uart_idle = 1'b1;
        uart_done = 1'b0;
        forever begin
            @(negedge clk);
            if (ser_en && rst_n && uart_valid && uart_idle) begin
                int n;
                cap = uart_data;
                out_q.push_back(cap);
                uart_idle = 1'b0;
                n = 0;
                while (rst_n && (n < ser_len || ser_stall) && n < 5000) begin
                    @(negedge clk);
                    n++;
                    if (rst_n && (uart_data !== cap || uart_valid !== 1'b0)) ser_bad++;
                end
                if (rst_n) begin
                    uart_done = 1'b1;
                    @(negedge clk);
                    uart_done = 1'b0;
                end
                uart_idle = 1'b1;
            end
        end
    end

    // Reference: every accepted byte is queued in order, except a repeated channel status
    // when running-status compression is built in.
    function automatic void model_accept(input logic [7:0] b);
`ifdef MIDI_RUNNING_STATUS_EN
        if (b >= 8'h80 && b <= 8'hEF) begin
            if (b == m_last) return;
            m_last = b;
        end else if (b >= 8'hF0 && b <= 8'hF7) begin
            m_last = 8'h00;
        end
`endif
        exp_q.push_back(b);
    endfunction

    function automatic int first_diff();
        if (out_q.size() != exp_q.size()) return -2;
        foreach (out_q[i]) if (out_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (in_ready) begin
            @(posedge clk);
            #1;
            model_accept(b);
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed %b for byte %h, required 1", in_ready, b);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_started(input int cnt);
        int n = 0;
        while (out_q.size() < cnt && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_q.size() < cnt) begin
            errors++;
            $display("FAIL start_timeout: started=%0d required=%0d", out_q.size(), cnt);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while ((busy || !uart_idle || uart_done) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy || !uart_idle) begin
            errors++;
            $display("FAIL drain_timeout: busy=%b uart_idle=%b required 0/1", busy, uart_idle);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || uart_valid !== 1'b0 || level !== 5'd0 || busy !== 1'b0 || uart_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b level=%0d busy=%b data=%h required 0 0 0 0 00",
                     in_ready, uart_valid, level, busy, uart_data);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_single();
        out_q.delete(); exp_q.delete();
        ser_en = 1'b1; ser_stall = 1'b0; ser_len = 3;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h90;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_accept(8'h90);
        @(negedge clk);
        checks++;
        if (uart_valid !== 1'b0 || level !== 5'd1) begin
            errors++;
            $display("FAIL single_k1: valid=%b level=%0d required 0 1", uart_valid, level);
        end
        @(negedge clk);
        checks++;
        if (uart_valid !== 1'b1 || uart_data !== 8'h90) begin
            errors++;
            $display("FAIL single_offer: valid=%b data=%h required 1 90", uart_valid, uart_data);
        end
        wait_drain();
        checks++;
        if (uart_valid !== 1'b0 || level !== 5'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after: valid=%b level=%0d busy=%b required 0 0 0", uart_valid, level, busy);
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL single_order: diff at %0d (got %0d bytes, required %0d)", d, out_q.size(), exp_q.size());
        end
    endtask

    task automatic test_fill();
        out_q.delete(); exp_q.delete();
        ser_stall = 1'b1;
        send_byte(8'hEE);
        wait_started(1);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        @(negedge clk);
        checks++;
        if (level !== 5'd16 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: level=%0d ready=%b required 16 0", level, in_ready);
        end
        in_valid = 1'b1; in_data = 8'h55;
        repeat (3) @(negedge clk);
        checks++;
        if (level !== 5'd16 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_17th: level=%0d ready=%b required 16 0", level, in_ready);
        end
        in_valid = 1'b0;
        ser_stall = 1'b0;
        wait_drain();
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL fill_order: diff at %0d (got %0d bytes, required %0d)", d, out_q.size(), exp_q.size());
        end
        checks++;
        if (ser_bad != 0) begin
            errors++;
            $display("FAIL fill_stable: unstable samples=%0d required 0", ser_bad);
        end
    endtask

    task automatic test_push_pop_wrap();
        logic [7:0] x;
        int n;
        out_q.delete(); exp_q.delete();
        ser_stall = 1'b1; ser_len = 2;
        send_byte(8'h11);
        wait_started(1);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 127)));
        @(negedge clk);
        checks++;
        if (level !== 5'd5) begin
            errors++;
            $display("FAIL pp_setup_level: got %0d required 5", level);
        end
        ser_stall = 1'b0;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!uart_done && n < 100);
        // Done seen; the pop edge is two edges later, align one push with it.
        @(negedge clk);
        x = 8'($urandom_range(0, 127));
        in_valid = 1'b1; in_data = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_accept(x);
        @(negedge clk);
        checks++;
        if (level !== 5'd5 || uart_valid !== 1'b1) begin
            errors++;
            $display("FAIL pp_same_cycle: level=%0d valid=%b required 5 1", level, uart_valid);
        end
        for (int i = 0; i < 40; i++) begin
            ser_len = $urandom_range(1, 4);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
            send_byte(8'($urandom_range(0, 255)));
        end
        wait_drain();
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL wrap_order: diff at %0d (got %0d bytes, required %0d)", d, out_q.size(), exp_q.size());
        end
        checks++;
        if (ser_bad != 0) begin
            errors++;
            $display("FAIL wrap_stable: unstable samples=%0d required 0", ser_bad);
        end
    endtask

    task automatic test_flush();
        out_q.delete(); exp_q.delete();
        ser_en = 1'b0; ser_stall = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i));
        @(negedge clk);
        checks++;
        if (uart_valid !== 1'b1 || uart_data !== 8'h21 || level !== 5'd3) begin
            errors++;
            $display("FAIL flush_offer_setup: valid=%b data=%h level=%0d required 1 21 3", uart_valid, uart_data, level);
        end
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got %b required 0", in_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0; m_last = 8'h00;
        @(negedge clk);
        checks++;
        if (uart_valid !== 1'b0 || level !== 5'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_offer: valid=%b level=%0d busy=%b required 0 0 0", uart_valid, level, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (uart_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_offer_quiet: valid=%b required 0", uart_valid);
        end

        out_q.delete(); exp_q.delete();
        ser_en = 1'b1; ser_stall = 1'b1; ser_len = 2;
        send_byte(8'hB0);
        wait_started(1);
        send_byte(8'h31);
        send_byte(8'h32);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; m_last = 8'h00;
        exp_q.delete(); exp_q.push_back(8'hB0);
        @(negedge clk);
        checks++;
        if (level !== 5'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_send_level: level=%0d busy=%b required 0 1", level, busy);
        end
        ser_stall = 1'b0;
        wait_drain();
        d = first_diff();
        checks++;
        if (d != -1 || uart_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_send_out: diff=%0d bytes=%0d valid=%b required -1 1 0", d, out_q.size(), uart_valid);
        end
        checks++;
        if (ser_bad != 0) begin
            errors++;
            $display("FAIL flush_send_stable: unstable samples=%0d required 0", ser_bad);
        end
    endtask

`ifdef MIDI_RUNNING_STATUS_EN
    task automatic test_running_status();
        logic [7:0] vin[10]  = '{8'h90, 8'h3C, 8'h40, 8'h90, 8'h3E, 8'h40, 8'hF8, 8'h90, 8'h40, 8'h40};
        logic [7:0] vout[8]  = '{8'h90, 8'h3C, 8'h40, 8'h3E, 8'h40, 8'hF8, 8'h40, 8'h40};
        out_q.delete(); exp_q.delete();
        ser_en = 1'b1; ser_stall = 1'b0; ser_len = 2;
        foreach (vin[i]) send_byte(vin[i]);
        wait_drain();
        exp_q.delete();
        foreach (vout[i]) exp_q.push_back(vout[i]);
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL rs_compress: diff at %0d (got %0d bytes, required 8)", d, out_q.size());
        end
        out_q.delete();
        send_byte(8'hF2);
        send_byte(8'h90);
        wait_drain();
        exp_q.delete(); exp_q.push_back(8'hF2); exp_q.push_back(8'h90);
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL rs_syscommon: diff at %0d (got %0d bytes, required 2)", d, out_q.size());
        end
    endtask
`endif

    task automatic test_reset_midframe();
        out_q.delete(); exp_q.delete();
        ser_en = 1'b1; ser_stall = 1'b1;
        send_byte(8'h45);
        wait_started(1);
        for (int i = 0; i < 4; i++) send_byte(8'h50 + 8'(i));
        @(negedge clk);
        checks++;
        if (level !== 5'd4) begin
            errors++;
            $display("FAIL rst_setup_level: got %0d required 4", level);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (uart_valid !== 1'b0 || level !== 5'd0 || in_ready !== 1'b0 || busy !== 1'b0 || uart_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_async: valid=%b level=%0d ready=%b busy=%b data=%h required 0 0 0 0 00",
                     uart_valid, level, in_ready, busy, uart_data);
        end
        ser_stall = 1'b0; m_last = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready: got %b required 1", in_ready);
        end
        // Reset while a byte is being offered must drop uart_valid without waiting for a clock.
        ser_en = 1'b0;
        send_byte(8'h66);
        repeat (2) @(negedge clk);
        checks++;
        if (uart_valid !== 1'b1 || uart_data !== 8'h66) begin
            errors++;
            $display("FAIL rst_offer_setup: valid=%b data=%h required 1 66", uart_valid, uart_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (uart_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_offer_async: valid=%b required 0", uart_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_last = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_push_pop_wrap();
        test_flush();
`ifdef MIDI_RUNNING_STATUS_EN
        test_running_status();
`endif
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
